// File: rtl/abcd_sweep_driver.sv
// abcd_sweep_driver: drives all 16 A..D vectors into the F/G evaluator,
// holds each for SETTLE cycles, samples F/G and checks them against a
// golden model (F = A&B&(C|D), G = (A|B)&C&D). SETTLE legal range 1..15.
module abcd_sweep_driver #(
   parameter int unsigned SETTLE = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       A,
   output logic       B,
   output logic       C,
   output logic       D,
   input  logic       F,
   input  logic       G,
   output logic       busy,
   output logic       done,
   output logic [4:0] f_count,
   output logic [4:0] g_count,
   output logic       err,
   output logic [3:0] err_vec,
   output logic [4:0] err_count
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_SAMPLE,
      S_DONE
   } state_t;

   localparam logic [3:0] WCNT_LAST = 4'(SETTLE - 1);

   state_t     state;
   state_t     state_nxt;
   logic [3:0] v;
   logic [3:0] wcnt;
   logic       accept;
   logic       sample;
   logic       exp_f;
   logic       exp_g;
   logic       mismatch;

   // The driven vector is a register, so A..D come straight from flops.
   assign A = v[3];
   assign B = v[2];
   assign C = v[1];
   assign D = v[0];

   // Golden model evaluated on the vector currently driven.
   assign exp_f    = v[3] & v[2] & (v[1] | v[0]);
   assign exp_g    = (v[3] | v[2]) & v[1] & v[0];
   assign mismatch = (F != exp_f) || (G != exp_g);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic and state-decoded status outputs.
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      accept    = 1'b0;
      sample    = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            busy = 1'b1;
            if (wcnt == WCNT_LAST) begin
               state_nxt = S_SAMPLE;
            end
         end
         S_SAMPLE: begin
            busy   = 1'b1;
            sample = 1'b1;
            if (v == 4'hF) begin
               state_nxt = S_DONE;
            end else begin
               state_nxt = S_WAIT;
            end
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Vector/settle counters and result accumulation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v         <= '0;
         wcnt      <= '0;
         f_count   <= '0;
         g_count   <= '0;
         err       <= 1'b0;
         err_vec   <= '0;
         err_count <= '0;
      end else if (accept) begin
         v         <= '0;
         wcnt      <= '0;
         f_count   <= '0;
         g_count   <= '0;
         err       <= 1'b0;
         err_vec   <= '0;
         err_count <= '0;
      end else if (state == S_WAIT) begin
         wcnt <= wcnt + 4'd1;
      end else if (sample) begin
         f_count <= f_count + 5'(F);
         g_count <= g_count + 5'(G);
         if (mismatch) begin
            err_count <= err_count + 5'd1;
            if (!err) begin
               err     <= 1'b1;
               err_vec <= v;
            end
         end
         // The last vector stays driven (1111) once the sweep ends.
         if (v != 4'hF) begin
            v    <= v + 4'd1;
            wcnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_abcd_sweep_driver.sv
// Testbench for abcd_sweep_driver: two instances (SETTLE=2 and SETTLE=1),
// each wired to a behavioural evaluator that can be correct, F-stuck-0,
// or F/G-swapped. Expected results are hand-computed constants.
module tb_abcd_sweep_driver;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_s [2];
   logic        a_s     [2];
   logic        b_s     [2];
   logic        c_s     [2];
   logic        d_s     [2];
   logic        f_s     [2];
   logic        g_s     [2];
   logic        busy_s  [2];
   logic        done_s  [2];
   logic        err_s   [2];
   logic [4:0]  fc_s    [2];
   logic [4:0]  gc_s    [2];
   logic [4:0]  ec_s    [2];
   logic [3:0]  ev_s    [2];
   int unsigned mode_s  [2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Evaluator under test: 0 = correct, 1 = F stuck at 0, 2 = F/G swapped.
   function automatic logic [1:0] eval(input int unsigned m, input logic a, input logic b,
                                       input logic c, input logic d);
      logic f;
      logic g;
      f = a & b & (c | d);
      g = (a | b) & c & d;
      case (m)
         1:       return {1'b0, g};
         2:       return {g, f};
         default: return {f, g};
      endcase
   endfunction

   assign {f_s[0], g_s[0]} = eval(mode_s[0], a_s[0], b_s[0], c_s[0], d_s[0]);
   assign {f_s[1], g_s[1]} = eval(mode_s[1], a_s[1], b_s[1], c_s[1], d_s[1]);

   abcd_sweep_driver #(.SETTLE(2)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start_s[0]),
      .A(a_s[0]), .B(b_s[0]), .C(c_s[0]), .D(d_s[0]),
      .F(f_s[0]), .G(g_s[0]),
      .busy(busy_s[0]), .done(done_s[0]),
      .f_count(fc_s[0]), .g_count(gc_s[0]),
      .err(err_s[0]), .err_vec(ev_s[0]), .err_count(ec_s[0])
   );

   abcd_sweep_driver #(.SETTLE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start_s[1]),
      .A(a_s[1]), .B(b_s[1]), .C(c_s[1]), .D(d_s[1]),
      .F(f_s[1]), .G(g_s[1]),
      .busy(busy_s[1]), .done(done_s[1]),
      .f_count(fc_s[1]), .g_count(gc_s[1]),
      .err(err_s[1]), .err_vec(ev_s[1]), .err_count(ec_s[1])
   );

   task automatic check(input string tag, input int obs, input int exp_v);
      checks++;
      if (obs != exp_v) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   function automatic int vec_of(input int i);
      return int'({a_s[i], b_s[i], c_s[i], d_s[i]});
   endfunction

   task automatic check_results(input string tag, input int i, input int ef, input int eg,
                                input int ee, input int eev, input int eec);
      check({tag, ".f_count"},   int'(fc_s[i]), ef);
      check({tag, ".g_count"},   int'(gc_s[i]), eg);
      check({tag, ".err"},       int'(err_s[i]), ee);
      check({tag, ".err_vec"},   int'(ev_s[i]), eev);
      check({tag, ".err_count"}, int'(ec_s[i]), eec);
   endtask

   // One start pulse, then follow the sweep: vector per busy cycle,
   // busy length, done pulse width and final results.
   task automatic run_sweep(input string tag, input int i, input int unsigned m, input int per,
                            input int ef, input int eg, input int ee, input int eev, input int eec);
      int busy_cyc;
      bit seen;
      mode_s[i] = m;
      @(negedge clk);
      start_s[i] = 1'b1;
      @(negedge clk);
      start_s[i] = 1'b0;
      busy_cyc = 0;
      seen = 1'b0;
      for (int n = 0; n < 400 && !seen; n++) begin
         if (done_s[i]) begin
            seen = 1'b1;
         end else begin
            if (busy_s[i]) begin
               check({tag, ".vec"}, vec_of(i), busy_cyc / per);
               busy_cyc++;
            end
            @(negedge clk);
         end
      end
      check({tag, ".done_seen"},    int'(seen), 1);
      check({tag, ".busy_cycles"},  busy_cyc, 16 * per);
      check({tag, ".busy_at_done"}, int'(busy_s[i]), 0);
      check({tag, ".vec_hold"},     vec_of(i), 15);
      check_results(tag, i, ef, eg, ee, eev, eec);
      @(negedge clk);
      check({tag, ".done_width"},   int'(done_s[i]), 0);
      check({tag, ".fc_stable"},    int'(fc_s[i]), ef);
   endtask

   initial begin
      int dcount;
      int err_at_done;
      int idle_bad;
      bit seen;

      rst_n      = 1'b0;
      start_s[0] = 1'b0;
      start_s[1] = 1'b0;
      mode_s[0]  = 0;
      mode_s[1]  = 0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst.vec",  vec_of(0), 0);
      check("rst.busy", int'(busy_s[0]), 0);
      check("rst.done", int'(done_s[0]), 0);
      check_results("rst", 0, 0, 0, 0, 0, 0);
      check("rst.busy1", int'(busy_s[1]), 0);
      rst_n = 1'b1;

      // Correct evaluator, F stuck at 0, F/G swapped
      run_sweep("good",  0, 0, 3, 3, 3, 0, 0, 0);
      run_sweep("stuck", 0, 1, 3, 0, 3, 1, 13, 3);
      run_sweep("swap",  0, 2, 3, 3, 3, 1, 7, 4);

      // start held high: one sweep, one done, then re-accept after one IDLE cycle
      mode_s[0] = 1;
      @(negedge clk);
      start_s[0] = 1'b1;
      dcount = 0;
      err_at_done = 0;
      for (int n = 1; n <= 49; n++) begin
         @(negedge clk);
         if (done_s[0]) begin
            dcount++;
            err_at_done = int'(err_s[0]);
         end
      end
      check("hold.done_count", dcount, 1);
      check("hold.err_first",  err_at_done, 1);
      @(negedge clk);
      check("hold.idle_busy", int'(busy_s[0]), 0);
      check("hold.idle_done", int'(done_s[0]), 0);
      mode_s[0] = 0;
      @(negedge clk);
      check("hold.rebusy",   int'(busy_s[0]), 1);
      check("hold.revec",    vec_of(0), 0);
      check("hold.reclr",    int'(err_s[0]), 0);
      check("hold.reclr_ec", int'(ec_s[0]), 0);
      start_s[0] = 1'b0;
      seen = 1'b0;
      for (int n = 0; n < 100 && !seen; n++) begin
         @(negedge clk);
         if (done_s[0]) seen = 1'b1;
      end
      check("hold.done2", int'(seen), 1);
      check_results("hold2", 0, 3, 3, 0, 0, 0);

      // Asynchronous reset mid-sweep (cycle 20, vector 6 driven)
      run_sweep("pre_rst", 0, 2, 3, 3, 3, 1, 7, 4);
      mode_s[0] = 0;
      @(negedge clk);
      start_s[0] = 1'b1;
      @(negedge clk);
      start_s[0] = 1'b0;
      repeat (19) @(negedge clk);
      check("mid.vec_before", vec_of(0), 6);
      #2 rst_n = 1'b0;
      #1;
      check("mid.vec",  vec_of(0), 0);
      check("mid.busy", int'(busy_s[0]), 0);
      check("mid.done", int'(done_s[0]), 0);
      check_results("mid", 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      idle_bad = 0;
      for (int n = 0; n < 60; n++) begin
         @(negedge clk);
         if (done_s[0] || busy_s[0]) idle_bad++;
      end
      check("mid.no_done", idle_bad, 0);
      run_sweep("post_rst", 0, 0, 3, 3, 3, 0, 0, 0);

      // SETTLE=1 instance
      run_sweep("s1", 1, 0, 2, 3, 3, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
